// File: rtl/serial_rx_pkg.sv
// Shared types and width helpers for the serial word receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int count_width(input int width);
        return (width > 0) ? $clog2(width + 1) : 1;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: free-running up counter with clear, flagging half-bit and full-bit terminal counts.
module rx_bit_timer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic Clr,
    input  logic clear,
    output logic half_done,
    output logic full_done
);

    localparam int TW = timer_width(CLKS_PER_BIT);

    logic [TW-1:0] count;

    assign half_done = (count == TW'(CLKS_PER_BIT / 2 - 1));
    assign full_done = (count == TW'(CLKS_PER_BIT - 1));

    // Wrap at the full-bit count so non-power-of-two bit times stay periodic.
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            count <= '0;
        end else if (clear || full_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_rx_word.sv
// Serial-to-parallel word receiver: LSB-first frames, mid-bit sampling, stop-bit check.
module serial_rx_word
    import serial_rx_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             Ser_in,
    input  logic             Rx_en,
    output logic [WIDTH-1:0] Par_out,
    output logic             Valid,
    output logic             Frame_err,
    output logic             Busy
);

    localparam int CW = count_width(WIDTH);

    rx_state_t        state, state_next;
    logic             ser_prev;
    logic [WIDTH-1:0] shift_reg, shift_next, par_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_next;
    logic             valid_next, frame_err_next;
    logic             timer_clear, half_done, full_done;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK      (CLK),
        .Clr      (Clr),
        .clear    (timer_clear),
        .half_done(half_done),
        .full_done(full_done)
    );

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            state     <= IDLE;
            ser_prev  <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            Par_out   <= '0;
            Valid     <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            ser_prev  <= Ser_in;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            Par_out   <= par_next;
            Valid     <= valid_next;
            Frame_err <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt;
        par_next       = Par_out;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        timer_clear    = 1'b0;

        unique case (state)
            IDLE: begin
                // Holding the timer clear here means it reads 0 right after the start edge.
                timer_clear = 1'b1;
                if (ser_prev && !Ser_in && Rx_en) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_done) begin
                    timer_clear  = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = Ser_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_done) begin
                    timer_clear             = 1'b1;
                    shift_next              = shift_reg >> 1;
                    shift_next[WIDTH-1]     = Ser_in;
                    bit_cnt_next            = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (full_done) begin
                    timer_clear = 1'b1;
                    if (Ser_in) begin
                        par_next   = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                timer_clear = 1'b1;
                if (Ser_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_rx_word.sv
// Self-checking bench for serial_rx_word: table of frames plus hand-written corner sequences, scoreboard on strobes.
module tb_serial_rx_word;

    localparam int W = 4;
    localparam int C = 4;
    localparam int H = C / 2;
    localparam int LAT = H + (W + 1) * C;

    logic         CLK;
    logic         Clr;
    logic         Ser_in;
    logic         Rx_en;
    logic [W-1:0] Par_out;
    logic         Valid;
    logic         Frame_err;
    logic         Busy;

    serial_rx_word #(
        .WIDTH       (W),
        .CLKS_PER_BIT(C)
    ) dut (
        .CLK      (CLK),
        .Clr      (Clr),
        .Ser_in   (Ser_in),
        .Rx_en    (Rx_en),
        .Par_out  (Par_out),
        .Valid    (Valid),
        .Frame_err(Frame_err),
        .Busy     (Busy)
    );

    // kind: 0 = no strobe, 1 = Valid, 2 = Frame_err
    typedef struct {
        int       kind;
        logic [W-1:0] par;
        int       cyc;
    } exp_t;

    typedef struct {
        logic         en;
        logic [W-1:0] d;
        logic         stop;
        bit           drop_en;
        int           kind;
        logic [W-1:0] par;
        int           busy;
        int           gap;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (Busy) busy_cnt++;
    endtask

    // Entered at a negedge; drives start, LSB-first data and stop, each C cycles.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int kind,
                              input logic [W-1:0] par, input bit drop_en);
        exp_t e;
        Ser_in = 1'b0;
        if (kind != 0) begin
            e.kind = kind;
            e.par  = par;
            e.cyc  = cyc + 1 + LAT;
            sb.push_back(e);
        end
        repeat (C) tick();
        if (drop_en) Rx_en = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            Ser_in = d[k];
            repeat (C) tick();
        end
        Ser_in = stop;
        repeat (C) tick();
    endtask

    always @(negedge CLK) begin
        if (Clr && (Valid || Frame_err)) begin
            exp_t e;
            check("strobe_exclusive", int'(Valid && Frame_err), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'(Valid) + 2 * int'(Frame_err), 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", Valid ? 1 : 2, e.kind);
                check("par_out", int'(Par_out), int'(e.par));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        tbl[0] = '{en: 1'b1, d: 4'hA, stop: 1'b1, drop_en: 1'b0, kind: 1, par: 4'hA, busy: LAT, gap: 3};
        tbl[1] = '{en: 1'b1, d: 4'h5, stop: 1'b1, drop_en: 1'b0, kind: 1, par: 4'h5, busy: LAT, gap: 0};
        tbl[2] = '{en: 1'b1, d: 4'hF, stop: 1'b1, drop_en: 1'b0, kind: 1, par: 4'hF, busy: LAT, gap: 2};
        tbl[3] = '{en: 1'b0, d: 4'h6, stop: 1'b1, drop_en: 1'b0, kind: 0, par: 4'hF, busy: 0,   gap: 2};
        tbl[4] = '{en: 1'b1, d: 4'h0, stop: 1'b1, drop_en: 1'b0, kind: 1, par: 4'h0, busy: LAT, gap: 0};
        tbl[5] = '{en: 1'b1, d: 4'h9, stop: 1'b1, drop_en: 1'b1, kind: 1, par: 4'h9, busy: LAT, gap: 2};

        Clr    = 1'b1;
        Ser_in = 1'b1;
        Rx_en  = 1'b1;
        #4 Clr = 1'b0;
        #5 Clr = 1'b1;

        @(negedge CLK);
        check("reset_par_out", int'(Par_out), 0);
        check("reset_valid", int'(Valid), 0);
        check("reset_frame_err", int'(Frame_err), 0);
        check("reset_busy", int'(Busy), 0);
        repeat (2) tick();

        for (int unsigned i = 0; i < 6; i++) begin
            Rx_en    = tbl[i].en;
            busy_cnt = 0;
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].kind, tbl[i].par, tbl[i].drop_en);
            repeat (tbl[i].gap) tick();
            check("row_busy_cycles", busy_cnt, tbl[i].busy);
            Rx_en = 1'b1;
        end

        // False start: one low cycle keeps the FSM busy for exactly half a bit.
        busy_cnt = 0;
        Ser_in = 1'b0;
        tick();
        Ser_in = 1'b1;
        repeat (2 * C) tick();
        check("false_start_busy", busy_cnt, H);

        // Framing error, line held low, then recovery with a good frame.
        send_frame(4'h3, 1'b0, 2, 4'h9, 1'b0);
        repeat (10) tick();
        check("break_hold_busy", int'(Busy), 1);
        Ser_in = 1'b1;
        tick();
        check("break_exit_busy", int'(Busy), 0);
        tick();
        send_frame(4'hC, 1'b1, 1, 4'hC, 1'b0);
        repeat (2) tick();

        // Asynchronous clear in the middle of DATA discards the partial word.
        Ser_in = 1'b0;
        repeat (C + 2 * C + 1) tick();
        check("mid_frame_busy", int'(Busy), 1);
        #2 Clr = 1'b0;
        #1;
        check("clr_async_busy", int'(Busy), 0);
        check("clr_par_out", int'(Par_out), 0);
        Ser_in = 1'b1;
        @(negedge CLK);
        Clr = 1'b1;
        busy_cnt = 0;
        repeat (30) tick();
        check("post_clr_busy", busy_cnt, 0);

        send_frame(4'h7, 1'b1, 1, 4'h7, 1'b0);
        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
